// File: rtl/execute_unit.sv
// execute_unit: execute/write-back stage with 16-entry register file, single-cycle ALU,
// iterative shift-add multiply (stalls upstream while busy) and register-indirect jumps.
module execute_unit #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        opcode,
    input  logic [3:0]        reg_a,
    input  logic [3:0]        reg_b,
    input  logic [3:0]        reg_c,
    input  logic [3:0]        imm_value,
    output logic              stall,
    output logic              jump_enable,
    output logic [DATA_W-1:0] jump_address,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int CW = $clog2(MUL_CYCLES + 1);
    typedef enum logic {IDLE, MUL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        dst_q, dst_d;
    logic              jump_enable_q, jump_enable_d, zero_q, zero_d, carry_q, carry_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] jump_address_q, jump_address_d, wb_data_q, wb_data_d;

    logic              accept, wr, upd_flags, carry_new;
    logic [DATA_W-1:0] ra_v, rb_v, rc_v, imm, res, acc_nx;

    assign stall        = (state_q == MUL);
    assign jump_enable  = jump_enable_q;
    assign jump_address = jump_address_q;
    assign zero_flag    = zero_q;
    assign carry_flag   = carry_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign dbg_data     = regs_q[dbg_addr];

    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        dst_d          = dst_q;
        zero_d         = zero_q;
        carry_d        = carry_q;
        jump_address_d = jump_address_q;
        wb_data_d      = wb_data_q;
        jump_enable_d  = 1'b0;
        wb_valid_d     = 1'b0;
        accept         = in_valid && (state_q == IDLE);
        ra_v           = regs_q[reg_a];
        rb_v           = regs_q[reg_b];
        rc_v           = regs_q[reg_c];
        imm            = {{(DATA_W-4){1'b0}}, imm_value};
        res            = '0;
        carry_new      = 1'b0;
        wr             = 1'b0;
        upd_flags      = 1'b0;
        acc_nx         = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (opcode)
            4'h1: begin {carry_new, res} = {1'b0, rb_v} + {1'b0, rc_v}; wr = 1'b1; upd_flags = 1'b1; end
            4'h2: begin {carry_new, res} = {1'b0, rb_v} - {1'b0, rc_v}; wr = 1'b1; upd_flags = 1'b1; end
            4'h3: begin res = rb_v & rc_v; wr = 1'b1; upd_flags = 1'b1; end
            4'h4: begin res = rb_v | rc_v; wr = 1'b1; upd_flags = 1'b1; end
            4'h5: begin res = rb_v ^ rc_v; wr = 1'b1; upd_flags = 1'b1; end
            4'h6: begin res = rb_v << imm_value; wr = 1'b1; upd_flags = 1'b1; end
            4'h7: begin res = rb_v >> imm_value; wr = 1'b1; upd_flags = 1'b1; end
            4'h8: begin res = imm; wr = 1'b1; end
            4'h9: begin {carry_new, res} = {1'b0, rb_v} + {1'b0, imm}; wr = 1'b1; upd_flags = 1'b1; end
            default: ;
        endcase
        if (accept) begin
            if (wr) begin
                if (reg_a != 4'd0)
                    regs_d[reg_a] = res;
                wb_valid_d = 1'b1;
                wb_data_d  = res;
            end
            if (upd_flags) begin
                zero_d  = (res == '0);
                carry_d = carry_new;
            end
            if (opcode == 4'hA) begin
                state_d  = MUL;
                mcand_d  = rb_v;
                mplier_d = rc_v;
                dst_d    = reg_a;
                acc_d    = '0;
                cnt_d    = '0;
            end
            if ((opcode == 4'hB && ra_v == rb_v) || opcode == 4'hC) begin
                jump_enable_d  = 1'b1;
                jump_address_d = (opcode == 4'hC) ? ra_v : rc_v;
            end
        end
        // Each MUL cycle folds in one multiplier bit; the last one also retires the result.
        if (state_q == MUL) begin
            acc_d    = acc_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(MUL_CYCLES - 1)) begin
                state_d = IDLE;
                if (dst_q != 4'd0)
                    regs_d[dst_q] = acc_nx;
                wb_valid_d = 1'b1;
                wb_data_d  = acc_nx;
                zero_d     = (acc_nx == '0);
                carry_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            regs_q         <= '{default: '0};
            mcand_q        <= '0;
            mplier_q       <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            dst_q          <= '0;
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
            jump_enable_q  <= 1'b0;
            jump_address_q <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            regs_q         <= regs_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            dst_q          <= dst_d;
            zero_q         <= zero_d;
            carry_q        <= carry_d;
            jump_enable_q  <= jump_enable_d;
            jump_address_q <= jump_address_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: table-driven directed vectors for single-cycle ops and jumps,
// plus hand-written sequences for multiply stall/hold and reset during a multiply.
module tb_execute_unit;
    logic        clk = 1'b0;
    logic        reset, in_valid;
    logic [3:0]  opcode, reg_a, reg_b, reg_c, imm_value, dbg_addr;
    logic        stall, jump_enable, zero_flag, carry_flag, wb_valid;
    logic [15:0] jump_address, wb_data, dbg_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    execute_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .imm_value(imm_value),
        .stall(stall), .jump_enable(jump_enable), .jump_address(jump_address),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .wb_valid(wb_valid),
        .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op, a, b, c, imm;
        logic        wv;
        logic [15:0] wd;
        logic        z, cy, je;
        logic [15:0] ja;
        logic [3:0]  ra;
        logic [15:0] rv;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, a, b, c, imm);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; reg_a = a; reg_b = b; reg_c = c; imm_value = imm;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] r, output logic [15:0] v);
        dbg_addr = r;
        #0 v = dbg_data;
    endtask

    initial begin
        logic [15:0] v;
        int          stall_cycles;
        vecs[0]  = '{4'h8, 4'd1, 4'd0, 4'd0, 4'd7,  1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0, 4'd1,  16'h0007};
        vecs[1]  = '{4'h8, 4'd2, 4'd0, 4'd0, 4'd9,  1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 16'h0, 4'd2,  16'h0009};
        vecs[2]  = '{4'h1, 4'd3, 4'd1, 4'd2, 4'd0,  1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0, 4'd3,  16'h0010};
        vecs[3]  = '{4'h2, 4'd4, 4'd1, 4'd2, 4'd0,  1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 16'h0, 4'd4,  16'hFFFE};
        vecs[4]  = '{4'h8, 4'd0, 4'd0, 4'd0, 4'd5,  1'b1, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0, 4'd0,  16'h0000};
        vecs[5]  = '{4'h1, 4'd5, 4'd0, 4'd0, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 4'd5,  16'h0000};
        vecs[6]  = '{4'h3, 4'd6, 4'd1, 4'd2, 4'd0,  1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 4'd6,  16'h0001};
        vecs[7]  = '{4'h4, 4'd7, 4'd1, 4'd2, 4'd0,  1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 16'h0, 4'd7,  16'h000F};
        vecs[8]  = '{4'h5, 4'd8, 4'd1, 4'd2, 4'd0,  1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 16'h0, 4'd8,  16'h000E};
        vecs[9]  = '{4'h9, 4'd9, 4'd4, 4'd0, 4'd2,  1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0, 4'd9,  16'h0000};
        vecs[10] = '{4'h7, 4'd10, 4'd4, 4'd0, 4'd4, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h0, 4'd10, 16'h0FFF};
        vecs[11] = '{4'h6, 4'd12, 4'd4, 4'd0, 4'd15, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 4'd12, 16'h0000};
        vecs[12] = '{4'h0, 4'd1, 4'd1, 4'd1, 4'd1,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 4'd1,  16'h0007};
        vecs[13] = '{4'hE, 4'd1, 4'd1, 4'd1, 4'd1,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 4'd1,  16'h0007};
        vecs[14] = '{4'h8, 4'd1, 4'd0, 4'd0, 4'd3,  1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0, 4'd1,  16'h0003};
        vecs[15] = '{4'h8, 4'd2, 4'd0, 4'd0, 4'd3,  1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0, 4'd2,  16'h0003};
        vecs[16] = '{4'h8, 4'd3, 4'd0, 4'd0, 4'd12, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 16'h0, 4'd3,  16'h000C};
        vecs[17] = '{4'hB, 4'd1, 4'd2, 4'd3, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000C, 4'd1, 16'h0003};
        vecs[18] = '{4'h8, 4'd2, 4'd0, 4'd0, 4'd4,  1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0, 4'd2,  16'h0004};
        vecs[19] = '{4'hB, 4'd1, 4'd2, 4'd3, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 4'd2,  16'h0004};
        vecs[20] = '{4'hC, 4'd3, 4'd0, 4'd0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000C, 4'd3, 16'h000C};
        vecs[21] = '{4'hD, 4'd3, 4'd3, 4'd3, 4'd3,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 4'd3,  16'h000C};

        reset = 1'b0; in_valid = 1'b0; opcode = '0; reg_a = '0; reg_b = '0; reg_c = '0;
        imm_value = '0; dbg_addr = '0;
        #3 reset = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_jump_en", jump_enable, 0);
        chk("rst_jump_addr", jump_address, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        for (int r = 0; r < 16; r++) begin
            rd(4'(r), v);
            chk($sformatf("rst_reg%0d", r), v, 0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].imm);
            chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].wv);
            if (vecs[i].wv) chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wd);
            chk($sformatf("v%0d_zero", i), zero_flag, vecs[i].z);
            chk($sformatf("v%0d_carry", i), carry_flag, vecs[i].cy);
            chk($sformatf("v%0d_jump_en", i), jump_enable, vecs[i].je);
            if (vecs[i].je) chk($sformatf("v%0d_jump_addr", i), jump_address, vecs[i].ja);
            chk($sformatf("v%0d_stall", i), stall, 0);
            rd(vecs[i].ra, v);
            chk($sformatf("v%0d_reg%0d", i, vecs[i].ra), v, vecs[i].rv);
        end

        // multiply with a held follow-on instruction
        issue(4'h8, 4'd1, 4'd0, 4'd0, 4'd15);
        issue(4'h6, 4'd2, 4'd1, 4'd0, 4'd12);
        chk("shl_wb_data", wb_data, 16'hF000);
        issue(4'hA, 4'd3, 4'd2, 4'd1, 4'd0);
        in_valid = 1'b1; opcode = 4'h9; reg_a = 4'd4; reg_b = 4'd3; reg_c = 4'd0; imm_value = 4'd1;
        stall_cycles = 0;
        for (int k = 1; k <= 16; k++) begin
            if (stall) stall_cycles++;
            @(posedge clk);
            #1;
            if (k < 16) chk($sformatf("mul_busy_wb_valid_%0d", k), wb_valid, 0);
        end
        chk("mul_stall_cycles", stall_cycles, 16);
        chk("mul_stall_dropped", stall, 0);
        chk("mul_wb_valid", wb_valid, 1);
        chk("mul_wb_data", wb_data, 16'h1000);
        chk("mul_zero", zero_flag, 0);
        chk("mul_carry", carry_flag, 0);
        rd(4'd3, v);
        chk("mul_reg3", v, 16'h1000);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("held_wb_valid", wb_valid, 1);
        chk("held_wb_data", wb_data, 16'h1001);
        rd(4'd4, v);
        chk("held_reg4", v, 16'h1001);

        // reset partway through a multiply
        issue(4'hA, 4'd11, 4'd1, 4'd1, 4'd0);
        chk("mul2_stall", stall, 1);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort_stall", stall, 0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 chk($sformatf("abort_wb_valid_%0d", k), wb_valid, 0);
            if (k == 2) reset = 1'b0;
        end
        rd(4'd11, v);
        chk("abort_reg11", v, 0);
        chk("abort_stall_end", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/execute_unit.md
# execute_unit

Execute/write-back stage directly downstream of `instruction_decoder`. Consumes the decoded fields, holds the 16×16-bit register file, and performs ALU ops, a 16-cycle shift-add multiply and register-indirect jumps. Jump requests return to `program_counter`. A stall output holds the upstream stages while a multiply runs.

## Interface
- `DATA_W`, 16: register and datapath width.
- `MUL_CYCLES`, 16: multiply iterations, equal to `DATA_W`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: decoded instruction present this cycle.
- `opcode` in 4: from decoder.
- `reg_a` in 4: destination, or first compare operand for BEQ/JMP.
- `reg_b` in 4: source 1.
- `reg_c` in 4: source 2, or branch target register.
- `imm_value` in 4: immediate, zero-extended to 16 bits.
- `stall` out 1: upstream must hold its instruction and not advance.
- `jump_enable` out 1: registered one-cycle pulse to the PC.
- `jump_address` out 16: target, valid while `jump_enable`=1.
- `zero_flag`, `carry_flag` out 1 each: registered ALU flags.
- `wb_valid` out 1: registered pulse; a register write happened on the last edge.
- `wb_data` out 16: value written at that edge.
- `dbg_addr` in 4 / `dbg_data` out 16: combinational register-file read port for benches.
- The decoder's `reg_d` field is not consumed.

## Operation
- Opcodes. "Accepted" means `in_valid`=1 and `stall`=0 at a rising edge.
  - 0x0 NOP.
  - 0x1 ADD: rA=rB+rC; carry = bit 16.
  - 0x2 SUB: rA=rB−rC; carry = borrow.
  - 0x3 AND, 0x4 OR, 0x5 XOR: rA=rB op rC.
  - 0x6 SHL, 0x7 SHR (logical): rA = rB shifted by imm (0–15).
  - 0x8 LDI: rA=zext(imm).
  - 0x9 ADDI: rA=rB+zext(imm); carry = bit 16.
  - 0xA MUL: rA = low 16 bits of rB×rC.
  - 0xB BEQ: if rA==rB, jump to value of rC.
  - 0xC JMP: jump to value of rA.
  - 0xD–0xF: treated as NOP.
- Register file:
  - R0 reads 0 always; writes to R0 are discarded, but `wb_valid`, `wb_data` and flags still update.
  - Reads are combinational from the current array.
  - A write at edge N is visible to the instruction accepted at edge N+1. No bypass is needed.
- Flags: `zero_flag` = (result==0) for opcodes 0x1–0x7, 0x9, 0xA. Carry is updated only by ADD/SUB/ADDI; other ops clear it. LDI, BEQ, JMP and NOP leave both flags unchanged.
- FSM has two states, IDLE and MUL:
  - IDLE → MUL on accepted MUL. Latch multiplicand=rB, multiplier=rC and destination; clear the accumulator; count=0.
  - In MUL, each cycle: if multiplier LSB is set, acc += multiplicand (mod 2^16). Then multiplicand<<=1, multiplier>>=1, count++.
  - MUL → IDLE on the edge where count reaches `MUL_CYCLES`. The register write, `wb_valid` and flags happen on that edge.
- `stall` = (state==MUL). It is combinational from state.
- BEQ/JMP do not write a register. `jump_enable` is asserted for exactly the one cycle after acceptance. `jump_address` holds its last value otherwise.

## Timing
- Reset values: all 16 registers 0, state IDLE, and `stall`, `jump_enable`, `jump_address`, flags, `wb_valid`, `wb_data` all 0.
- Reset mid-MUL aborts the multiply: no write, `stall` drops immediately.
- Single-cycle ops: accepted at edge N, then register, flags, `wb_valid` and `wb_data` update at edge N.
- MUL timing:
  - Accepted at edge N; `stall`=1 from after edge N through edge N+16.
  - Write at edge N+16; `stall` low after N+16.
  - The next instruction is accepted at edge N+17 at the earliest.
- Instructions presented while `stall`=1 are ignored and must be re-presented; the decoder holds them naturally.
- `in_valid`=0 means no state change except MUL progress. `wb_valid` and `jump_enable` return to 0.
- Simultaneous events:
  - BEQ/JMP after a MUL is accepted only once the stall drops.
  - Jump and write never occur in the same cycle.

## Test plan
- Reset: assert `reset` mid-cycle, then release. Required: all outputs 0; `dbg_data` reads 0 for every address; `stall`=0.
- LDI R1,7; LDI R2,9; ADD R3,R1,R2; SUB R4,R1,R2. Required:
  - R3=0x0010, zero=0, carry=0.
  - R4=0xFFFE, carry=1.
  - `wb_valid` pulses on each edge.
- LDI R0,5 then ADD R5,R0,R0. Required: `dbg_data`(R0)=0 and R5=0 with `zero_flag`=1.
- LDI R1,15; SHL R2,R1,imm=12; MUL R3,R2,R1. Required:
  - R2=0xF000.
  - `stall` high exactly 16 cycles.
  - R3=0x1000 (low 16 bits of 0xF000×15=0xE1000) written at edge N+16.
  - The instruction held during the stall executes at N+17.
- LDI R1,3; LDI R2,3; LDI R3,12; BEQ R1,R2,R3. Required: `jump_enable` one-cycle pulse with `jump_address`=0x000C. With R2=4 instead, no pulse and no register change.
- Start a MUL, assert `reset` at count 8. Required: `stall` drops immediately, destination stays 0, `wb_valid` never pulses.
